modbus_uart_rx: RTL and testbench
=================================

Name: modbus_uart_rx

Overview:
Asynchronous serial byte receiver directly upstream of the Modbus RTU frame assembler; feeds it one data byte plus a one-cycle Enable strobe per received character.
- Oversamples the rxd line with a clock-divided bit timer.
- Validates start, stop and (optionally) parity bits.
- Flags Modbus RTU inter-frame silence (t3.5) so the downstream stage can resynchronise.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200); minimum 8
GAP_BITS, 39, idle bit-times that constitute an inter-frame gap (3.5 chars x 11 bits, rounded up)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rxd  input  1  serial line, idle high, asynchronous to clk
dataout  output  8  last accepted byte, LSB received first
Enable  output  1  one-cycle strobe: dataout valid and new
frame_err  output  1  one-cycle strobe: stop bit sampled low
parity_err  output  1  one-cycle strobe: parity mismatch (0 when feature disabled)
frame_gap  output  1  one-cycle strobe: GAP_BITS of idle after at least one byte
busy  output  1  high from start-edge detect until return to IDLE

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. Reset forces every output to 0, FSM to IDLE, both synchroniser flops to 1, gap counter to 0, gap_armed to 0. Reset mid-character aborts it with no strobes.
- rxd passes through a 2-flop synchroniser (rxd_s). All timing below is relative to rxd_s.
- H = CLKS_PER_BIT/2 (integer). Bit timer runs 0..CLKS_PER_BIT-1 in each bit period. Samples are taken at counts H-1, H, H+1. The bit value is the 2-of-3 majority, decided at count H+1.
- States:
  - IDLE: waits for a falling edge (prev rxd_s=1, now 0). On the edge, go to START with timer=0 and busy=1.
  - START: at decision, majority 1 = glitch; return to IDLE with no strobe. Majority 0: continue to count CLKS_PER_BIT-1, then go to DATA with bit index 0.
  - DATA: shift the decided bit into shift[7] (right shift, LSB first). After the 8th bit period completes, go to PARITY if the feature is enabled, else STOP.
  - PARITY: decide the bit; store the mismatch vs even parity of shift; at end of period go to STOP.
  - STOP: decision at H+1, then return to IDLE immediately; no wait to the end of the period, so back-to-back characters are not missed.
- STOP outcome is registered on the cycle after the decision:
  - stop=1, no parity error: dataout <= shift, Enable=1 for one cycle, gap_armed <= 1.
  - stop=0: frame_err=1; dataout unchanged; Enable=0. If a parity error also exists, parity_err=1 in the same cycle.
  - stop=1 with parity error: parity_err=1, Enable=0, dataout unchanged.
- A held-low line (break) after a frame error produces no further activity until rxd_s returns high, because IDLE requires a falling edge.
- Latency: Enable rises H+2 clocks after the stop bit begins on rxd_s (H+4 from the pin).
- Gap counter:
  - Counts clocks while in IDLE with rxd_s=1; cleared on any falling edge or when leaving IDLE; saturates.
  - When it reaches GAP_BITS*CLKS_PER_BIT and gap_armed=1: frame_gap=1 for one cycle, gap_armed <= 0.
  - No repeated gaps without an intervening good byte.
- Enable and frame_gap can never coincide, because the gap requires idle time after the last Enable.

Optional Feature:
MODBUS_UART_PARITY_EN
- Defined: 8E1 framing; PARITY state present; parity_err active as specified above.
- Undefined: 8N1 framing; PARITY state and logic are absent; parity_err is tied to 0. An 8N2 sender is accepted, because the extra stop bit is seen as idle.

Test Plan:
1. CLKS_PER_BIT=16, send 0x02 8N1 -> dataout=0x02, Enable high exactly one cycle, 10 clocks after stop-bit start on rxd_s; frame_err=0.
2. rxd low pulse of 4 clocks in IDLE -> START rejects it, busy drops, no Enable/frame_err; a following 0x06 is received correctly.
3. Send 0x10 after a good 0x02 with the stop bit forced low -> frame_err one cycle, Enable=0, dataout stays 0x02.
4. Back-to-back 0x02, 0x10, then hold rxd high -> two Enables; frame_gap pulses once at 624 idle clocks (39x16) and never again while idle; a new byte re-arms it.
5. With MODBUS_UART_PARITY_EN: 0x03 with parity bit 0 -> Enable, dataout=0x03. Same byte with parity bit 1 -> parity_err one cycle, no Enable.
6. Assert rst_n low during data bit 4, release, send 0xA5 -> all outputs 0 during reset; after release, dataout=0xA5 with one Enable and no spurious strobes.

Source files
------------

// File: rtl/modbus_uart_rx_if.sv
// Output bundle from the Modbus RTU byte receiver toward the frame assembler.
// The receiver drives it through the master modport and the frame assembler reads it through slave.
interface modbus_uart_rx_if;
    logic [7:0] dataout;
    logic       Enable;
    logic       frame_err;
    logic       parity_err;
    logic       frame_gap;
    logic       busy;

    modport master (output dataout, Enable, frame_err, parity_err, frame_gap, busy);
    modport slave  (input  dataout, Enable, frame_err, parity_err, frame_gap, busy);
endinterface

// File: rtl/modbus_uart_rx.sv
// Oversampling UART byte receiver with t3.5 inter-frame gap detection for Modbus RTU.
// Define MODBUS_UART_PARITY_EN for 8E1 framing; the default build is 8N1 with parity_err tied low.
module modbus_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_BITS     = 39
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    modbus_uart_rx_if.master rx
);
    localparam int H        = CLKS_PER_BIT / 2;
    localparam int TW       = $clog2(CLKS_PER_BIT);
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GW       = $clog2(GAP_CLKS + 1);

    localparam logic [TW-1:0] T_S0  = TW'(H - 1);
    localparam logic [TW-1:0] T_S1  = TW'(H);
    localparam logic [TW-1:0] T_DEC = TW'(H + 1);
    localparam logic [TW-1:0] T_END = TW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CLKS);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef MODBUS_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic          rxd_meta, rxd_s, rxd_prev;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          s0, s1;
    logic [GW-1:0] gap_cnt;
    logic          gap_armed;
    logic          par_err_q;

    logic maj, fall, at_dec, at_end, accept;

    assign maj    = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
    assign fall   = rxd_prev & ~rxd_s;
    assign at_dec = (timer == T_DEC);
    assign at_end = (timer == T_END);
    assign accept = (state == STOP) && at_dec && maj && !par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // The edge-detect cycle itself counts as count 0 of the start bit, so the timer is loaded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            rx.dataout   <= '0;
            rx.Enable    <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.busy      <= 1'b0;
        end else begin
            rx.Enable    <= 1'b0;
            rx.frame_err <= 1'b0;
            if (timer == T_S0) s0 <= rxd_s;
            if (timer == T_S1) s1 <= rxd_s;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (fall) begin
                        state   <= START;
                        timer   <= TW'(1);
                        rx.busy <= 1'b1;
                    end
                end
                START: begin
                    timer <= at_end ? '0 : timer + 1'b1;
                    if (at_dec && maj) begin
                        state   <= IDLE;
                        timer   <= '0;
                        rx.busy <= 1'b0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    timer <= at_end ? '0 : timer + 1'b1;
                    if (at_dec) shift <= {maj, shift[7:1]};
                    if (at_end) begin
                        bit_idx <= bit_idx + 1'b1;
`ifdef MODBUS_UART_PARITY_EN
                        if (bit_idx == 3'd7) state <= PARITY;
`else
                        if (bit_idx == 3'd7) state <= STOP;
`endif
                    end
                end
`ifdef MODBUS_UART_PARITY_EN
                PARITY: begin
                    timer <= at_end ? '0 : timer + 1'b1;
                    if (at_end) state <= STOP;
                end
`endif
                // Return to IDLE right at the decision so a back-to-back start edge is not missed.
                STOP: begin
                    timer <= timer + 1'b1;
                    if (at_dec) begin
                        state        <= IDLE;
                        timer        <= '0;
                        rx.busy      <= 1'b0;
                        rx.frame_err <= ~maj;
                        if (maj && !par_err_q) begin
                            rx.dataout <= shift;
                            rx.Enable  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    timer   <= '0;
                    rx.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef MODBUS_UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q     <= 1'b0;
            rx.parity_err <= 1'b0;
        end else begin
            rx.parity_err <= 1'b0;
            if (state == PARITY && at_dec) par_err_q <= maj ^ (^shift);
            if (state == STOP && at_dec) rx.parity_err <= par_err_q;
        end
    end
`else
    assign par_err_q     = 1'b0;
    assign rx.parity_err = 1'b0;
`endif

    // Idle-line timer: only an accepted byte arms it, so a gap is flagged at most once per burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt      <= '0;
            gap_armed    <= 1'b0;
            rx.frame_gap <= 1'b0;
        end else begin
            rx.frame_gap <= 1'b0;
            if (state != IDLE || fall) begin
                gap_cnt <= '0;
            end else if (rxd_s && gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST && gap_armed) begin
                    rx.frame_gap <= 1'b1;
                    gap_armed    <= 1'b0;
                end
            end
            if (accept) gap_armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_modbus_uart_rx.sv
// Bench for modbus_uart_rx at CLKS_PER_BIT=16: directed and random characters checked
// against a time-stamped event model derived from the framing and gap rules.
`timescale 1ns/1ps
module tb_modbus_uart_rx;
    localparam int     CPB   = 16;
    localparam int     GAP   = 39;
    localparam int     H     = CPB / 2;
    localparam longint P     = 10;
    localparam longint SYNC  = 15;
    localparam longint BIT_T = CPB * P;
    localparam longint GAP_T = GAP * CPB * P;
`ifdef MODBUS_UART_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
        longint     t;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rxd = 1'b1;

    int compare_count  = 0;
    int mismatch_count = 0;

    ev_t        exp_q[$];
    logic [7:0] last_good  = 8'h00;
    bit         armed      = 1'b0;
    longint     quiet_from = 0;

    modbus_uart_rx_if rx();

    modbus_uart_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Every strobe seen must match the oldest outstanding model event in kind, data and time.
    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t        e;
        obs = {rx.frame_gap, rx.parity_err, rx.frame_err, rx.Enable};
        if (rst_n === 1'b1 && obs !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", obs, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("strobe_kind", obs, e.kind);
                checkOutput("dataout", rx.dataout, e.data);
                checkOutput("strobe_time", $time, e.t);
            end
        end
    end

    // Line high for nbits bit-times; a gap is due if the idle, armed line outlasts GAP bit-times.
    task automatic idleBits(input int nbits);
        longint t_act;
        rxd   = 1'b1;
        t_act = $time + nbits * BIT_T;
        if (armed && (t_act + SYNC >= quiet_from + GAP_T)) begin
            exp_q.push_back('{4'b1000, last_good, quiet_from + GAP_T + P / 2});
            armed = 1'b0;
        end
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_flip, input int idle);
        logic [10:0] frame;
        int          nb;
        bit          perr;
        bit          good;
        longint      t_stop;
        if (!stop_bit && idle < 1) idle = 1;
        perr = PARITY && par_flip;
        good = stop_bit && !perr;
        if (PARITY) begin
            frame = {stop_bit, (^data) ^ par_flip, data, 1'b0};
            nb    = 11;
        end else begin
            frame = {1'b0, stop_bit, data, 1'b0};
            nb    = 10;
        end
        t_stop = $time + (nb - 1) * BIT_T;
        if (good) last_good = data;
        exp_q.push_back('{{1'b0, perr, !stop_bit, good}, last_good, t_stop + SYNC + (H + 2) * P + P / 2});
        for (int i = 0; i < nb; i++) begin
            rxd = frame[i];
            if (i == 5) checkOutput("busy_mid_char", rx.busy, 1);
            repeat (CPB) @(negedge clk);
        end
        checkOutput("busy_after_stop", rx.busy, 0);
        if (good) armed = 1'b1;
        if (stop_bit) quiet_from = t_stop + SYNC + (H + 2) * P;
        else          quiet_from = t_stop + BIT_T + SYNC;
        idleBits(idle);
    endtask

    task automatic applyGlitch(input int len, input int idle);
        longint t_g;
        t_g = $time;
        rxd = 1'b0;
        repeat (len) @(negedge clk);
        rxd = 1'b1;
        quiet_from = t_g + SYNC + (H + 2) * P;
        idleBits(idle);
        checkOutput("busy_after_glitch", rx.busy, 0);
    endtask

    task automatic applyResetMidChar(input logic [7:0] data);
        checkOutput("queue_before_reset", exp_q.size(), 0);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rxd = data[i];
            repeat (i == 4 ? H : CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_dataout", rx.dataout, 0);
        checkOutput("midreset_strobes", {rx.frame_gap, rx.parity_err, rx.frame_err, rx.Enable}, 0);
        checkOutput("midreset_busy", rx.busy, 0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        last_good = 8'h00;
        armed     = 1'b0;
        idleBits(2);
    endtask

    initial begin
        logic [7:0] d;
        bit         stop_b;
        bit         flip;
        int         idle;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dataout", rx.dataout, 0);
        checkOutput("reset_strobes", {rx.frame_gap, rx.parity_err, rx.frame_err, rx.Enable}, 0);
        checkOutput("reset_busy", rx.busy, 0);
        rst_n = 1'b1;
        idleBits(2);

        applyStimulus(8'h02, 1'b1, 1'b0, 3);
        applyGlitch(4, 3);
        applyStimulus(8'h06, 1'b1, 1'b0, 2);
        applyStimulus(8'h02, 1'b1, 1'b0, 2);
        applyStimulus(8'h10, 1'b0, 1'b0, 2);
        applyStimulus(8'h02, 1'b1, 1'b0, 0);
        applyStimulus(8'h10, 1'b1, 1'b0, 50);
        applyGlitch(4, 50);
        applyStimulus(8'h03, 1'b1, 1'b0, 2);
        applyStimulus(8'h03, 1'b1, 1'b1, 2);
        applyResetMidChar(8'h5A);
        applyStimulus(8'hA5, 1'b1, 1'b0, 3);

        for (int n = 0; n < 40; n++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 7) != 0);
            flip   = ($urandom_range(0, 7) == 0);
            idle   = ($urandom_range(0, 9) == 0) ? 45 + int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
            applyStimulus(d, stop_b, flip, idle);
            if ($urandom_range(0, 9) == 0) applyGlitch(int'($urandom_range(1, H - 2)), 2);
        end

        idleBits(50);
        repeat (20) @(negedge clk);
        checkOutput("events_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
